ras_spec_scheduler: RTL and testbench

- Sequences all commands into the return-address-stack datapath: frontend push/pop/branch-open requests and out-of-order branch resolutions.
- Tracks outstanding speculative branches in age order.
- Retires them to the stack strictly oldest-first (close_valid); flushes on the oldest mispredict (close_invalid).
- Guarantees at most one stack command per cycle and prevents close starvation.

---
 rtl/ras_spec_scheduler_if.sv | 37 +++
 rtl/ras_spec_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_ras_spec_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_spec_scheduler_if.sv
// Frontend, resolution and stack-command signals of ras_spec_scheduler.
// The master side is the frontend/branch unit and the slave side is the scheduler.
interface ras_spec_scheduler_if #(
  parameter int unsigned BRANCHES_ADDR = 4,
  parameter int unsigned WIDTH         = 32
);
  logic                     fe_valid;
  logic [1:0]               fe_op;
  logic [WIDTH-1:0]         fe_data;
  logic                     fe_ready;
  logic [BRANCHES_ADDR-1:0] fe_tag;
  logic                     rs_valid;
  logic [BRANCHES_ADDR-1:0] rs_tag;
  logic                     rs_mispredict;
  logic                     ras_push;
  logic                     ras_pop;
  logic                     ras_branch;
  logic                     ras_close_valid;
  logic                     ras_close_invalid;
  logic [WIDTH-1:0]         ras_din;
  logic [BRANCHES_ADDR:0]   outstanding;
  logic                     full;
  logic                     flush_done;
  logic                     rs_err;

  modport master (
    output fe_valid, fe_op, fe_data, rs_valid, rs_tag, rs_mispredict,
    input  fe_ready, fe_tag, ras_push, ras_pop, ras_branch, ras_close_valid,
    input  ras_close_invalid, ras_din, outstanding, full, flush_done, rs_err
  );

  modport slave (
    input  fe_valid, fe_op, fe_data, rs_valid, rs_tag, rs_mispredict,
    output fe_ready, fe_tag, ras_push, ras_pop, ras_branch, ras_close_valid,
    output ras_close_invalid, ras_din, outstanding, full, flush_done, rs_err
  );
endinterface

// File: rtl/ras_spec_scheduler.sv
// Serialises frontend ops and in-order branch retirement/flush onto the return-address stack.
// Optional resolution/underflow error checking is enabled by defining RAS_SPEC_SCHED_ERRCHK_EN.
module ras_spec_scheduler #(
  parameter int unsigned MAXBRANCHES   = 16,
  parameter int unsigned BRANCHES_ADDR = 4,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned MAX_DEFER     = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  ras_spec_scheduler_if.slave bus
);
  localparam int unsigned PtrW   = BRANCHES_ADDR + 1;
  localparam int unsigned DeferW = $clog2(MAX_DEFER + 1);
  localparam logic [1:0] OpPush   = 2'b00;
  localparam logic [1:0] OpPop    = 2'b01;
  localparam logic [1:0] OpRepl   = 2'b10;
  localparam logic [1:0] OpBranch = 2'b11;

  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

  state_e                   r_state;
  logic [PtrW-1:0]          r_head, r_tail;
  logic [MAXBRANCHES-1:0]   r_valid, r_resolved, r_mispred;
  logic [DeferW-1:0]        r_defer;
  logic                     r_push, r_pop, r_branch, r_close_valid, r_close_invalid;
  logic                     r_flush_done;
  logic [WIDTH-1:0]         r_din;

  logic [BRANCHES_ADDR-1:0] w_head_idx, w_tail_idx;
  logic [PtrW-1:0]          w_outstanding;
  logic                     w_full, w_run, w_flush_pending, w_close_ready, w_defer_max;
  logic                     w_fe_ready, w_fe_fire, w_close, w_rs_take;

  assign w_head_idx      = r_head[BRANCHES_ADDR-1:0];
  assign w_tail_idx      = r_tail[BRANCHES_ADDR-1:0];
  assign w_outstanding   = r_tail - r_head;
  assign w_full          = (w_outstanding == PtrW'(MAXBRANCHES));
  assign w_run           = (r_state == StRun);
  assign w_flush_pending = w_run && r_valid[w_head_idx] && r_resolved[w_head_idx]
                           && r_mispred[w_head_idx];
  assign w_close_ready   = r_valid[w_head_idx] && r_resolved[w_head_idx] && !r_mispred[w_head_idx];
  assign w_defer_max     = (r_defer == DeferW'(MAX_DEFER));
  assign w_fe_ready      = w_run && !w_flush_pending && !(w_defer_max && w_close_ready)
                           && !((bus.fe_op == OpBranch) && w_full);
  assign w_fe_fire       = bus.fe_valid && w_fe_ready;
  // A close never shares a cycle with an accepted frontend op, keeping commands exclusive.
  assign w_close         = w_run && w_close_ready && !w_fe_fire;
  assign w_rs_take       = w_run && bus.rs_valid && r_valid[bus.rs_tag] && !r_resolved[bus.rs_tag];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StRun;
      r_head          <= '0;
      r_tail          <= '0;
      r_valid         <= '0;
      r_resolved      <= '0;
      r_mispred       <= '0;
      r_defer         <= '0;
      r_push          <= 1'b0;
      r_pop           <= 1'b0;
      r_branch        <= 1'b0;
      r_close_valid   <= 1'b0;
      r_close_invalid <= 1'b0;
      r_flush_done    <= 1'b0;
      r_din           <= '0;
    end else begin
      r_push          <= 1'b0;
      r_pop           <= 1'b0;
      r_branch        <= 1'b0;
      r_close_valid   <= 1'b0;
      r_close_invalid <= 1'b0;
      r_flush_done    <= 1'b0;
      r_din           <= '0;
      unique case (r_state)
        StRun: begin
          if (w_flush_pending) begin
            r_state         <= StFlush;
            r_close_invalid <= 1'b1;
            r_valid         <= '0;
            r_resolved      <= '0;
            r_mispred       <= '0;
            r_head          <= r_tail;
            r_defer         <= '0;
          end else begin
            if (w_rs_take) begin
              r_resolved[bus.rs_tag] <= 1'b1;
              r_mispred[bus.rs_tag]  <= bus.rs_mispredict;
            end
            if (w_close) begin
              r_close_valid          <= 1'b1;
              r_valid[w_head_idx]    <= 1'b0;
              r_resolved[w_head_idx] <= 1'b0;
              r_mispred[w_head_idx]  <= 1'b0;
              r_head                 <= r_head + PtrW'(1);
              r_defer                <= '0;
            end else if (w_close_ready && !w_defer_max) begin
              r_defer <= r_defer + DeferW'(1);
            end
            if (w_fe_fire) begin
              unique case (bus.fe_op)
                OpPush: begin
                  r_push <= 1'b1;
                  r_din  <= bus.fe_data;
                end
                OpPop: r_pop <= 1'b1;
                OpRepl: begin
                  r_push <= 1'b1;
                  r_pop  <= 1'b1;
                  r_din  <= bus.fe_data;
                end
                OpBranch: begin
                  r_branch               <= 1'b1;
                  r_valid[w_tail_idx]    <= 1'b1;
                  r_resolved[w_tail_idx] <= 1'b0;
                  r_mispred[w_tail_idx]  <= 1'b0;
                  r_tail                 <= r_tail + PtrW'(1);
                end
                default: ;
              endcase
            end
          end
        end
        StFlush: begin
          r_state      <= StDrain;
          r_flush_done <= 1'b1;
        end
        StDrain: r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

`ifdef RAS_SPEC_SCHED_ERRCHK_EN
  localparam int unsigned DepthMax = MAXBRANCHES * 2;
  localparam int unsigned DepthW   = $clog2(DepthMax + 1);

  logic [DepthW-1:0] r_depth;
  logic              r_rs_err;
  logic              w_err;

  always_comb begin
    w_err = 1'b0;
    if (w_run) begin
      if (bus.rs_valid && (!r_valid[bus.rs_tag] || r_resolved[bus.rs_tag])) w_err = 1'b1;
      if (bus.fe_valid && (bus.fe_op == OpBranch) && w_full) w_err = 1'b1;
      if (bus.fe_valid && ((bus.fe_op == OpPop) || (bus.fe_op == OpRepl))
          && (w_outstanding == '0) && (r_depth == '0)) w_err = 1'b1;
    end
  end

  // After a flush the stack depth is unknown, so assume non-empty rather than raise false errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth  <= '0;
      r_rs_err <= 1'b0;
    end else begin
      if (w_err) r_rs_err <= 1'b1;
      if (w_flush_pending) begin
        r_depth <= DepthW'(DepthMax);
      end else if (w_fe_fire) begin
        if ((bus.fe_op == OpPush) && (r_depth != DepthW'(DepthMax))) begin
          r_depth <= r_depth + DepthW'(1);
        end else if ((bus.fe_op == OpPop) && (r_depth != '0)) begin
          r_depth <= r_depth - DepthW'(1);
        end
      end
    end
  end

  assign bus.rs_err = r_rs_err;
`else
  assign bus.rs_err = 1'b0;
`endif

  assign bus.fe_ready          = w_fe_ready;
  assign bus.fe_tag            = w_tail_idx;
  assign bus.ras_push          = r_push;
  assign bus.ras_pop           = r_pop;
  assign bus.ras_branch        = r_branch;
  assign bus.ras_close_valid   = r_close_valid;
  assign bus.ras_close_invalid = r_close_invalid;
  assign bus.ras_din           = r_din;
  assign bus.outstanding       = w_outstanding;
  assign bus.full              = w_full;
  assign bus.flush_done        = r_flush_done;
endmodule

// File: tb/tb_ras_spec_scheduler.sv
// Directed bench for ras_spec_scheduler: expected stack commands go into a queue that a
// negedge monitor drains whenever the DUT issues a command.
`timescale 1ns/1ps
module tb_ras_spec_scheduler;
  localparam int unsigned MaxBr    = 16;
  localparam int unsigned Addr     = 4;
  localparam int unsigned Width    = 32;
  localparam int unsigned MaxDefer = 8;
`ifdef RAS_SPEC_SCHED_ERRCHK_EN
  localparam logic ErrChk = 1'b1;
`else
  localparam logic ErrChk = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ras_spec_scheduler_if #(.BRANCHES_ADDR(Addr), .WIDTH(Width)) bus ();

  ras_spec_scheduler #(
    .MAXBRANCHES  (MaxBr),
    .BRANCHES_ADDR(Addr),
    .WIDTH        (Width),
    .MAX_DEFER    (MaxDefer)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             push;
    logic             pop;
    logic             branch;
    logic             cv;
    logic             ci;
    logic [Width-1:0] din;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic cmd_t mk(input logic push, input logic pop, input logic branch,
                              input logic cv, input logic ci, input logic [Width-1:0] din);
    cmd_t c;
    c.push = push; c.pop = pop; c.branch = branch; c.cv = cv; c.ci = ci; c.din = din;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fe_valid = 1'b0;
    bus.rs_valid = 1'b0;
  endtask

  // Presents one frontend op for a cycle, expecting it to be accepted.
  task automatic send(input logic [1:0] op, input logic [Width-1:0] data, input logic [Addr-1:0] tag);
    logic has_push;
    bus.fe_valid = 1'b1;
    bus.fe_op    = op;
    bus.fe_data  = data;
    #1;
    check("fe_ready_send", bus.fe_ready, 1);
    if (op == 2'b11) check("fe_tag", bus.fe_tag, tag);
    has_push = (op == 2'b00) || (op == 2'b10);
    exp_q.push_back(mk(has_push, (op == 2'b01) || (op == 2'b10), op == 2'b11, 1'b0, 1'b0,
                       has_push ? data : '0));
    @(posedge clk);
    #1;
    bus.fe_valid = 1'b0;
  endtask

  task automatic resolve(input logic [Addr-1:0] tag, input logic mis);
    bus.rs_valid      = 1'b1;
    bus.rs_tag        = tag;
    bus.rs_mispredict = mis;
    step();
    bus.rs_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    cmd_t got;
    cmd_t want;
    if (rst_n && (bus.ras_push || bus.ras_pop || bus.ras_branch || bus.ras_close_valid
                  || bus.ras_close_invalid)) begin
      got = mk(bus.ras_push, bus.ras_pop, bus.ras_branch, bus.ras_close_valid,
               bus.ras_close_invalid, bus.ras_din);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got %h expected none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL ras_cmd: got %h expected %h", got, want);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    idle();
    bus.fe_op         = 2'b00;
    bus.fe_data       = '0;
    bus.rs_tag        = '0;
    bus.rs_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outstanding", bus.outstanding, 0);
    check("reset_full", bus.full, 0);
    check("reset_flush_done", bus.flush_done, 0);
    check("reset_rs_err", bus.rs_err, 0);
    check("reset_cmds", {bus.ras_push, bus.ras_pop, bus.ras_branch, bus.ras_close_valid,
                         bus.ras_close_invalid}, 0);
    check("reset_din", bus.ras_din, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", bus.fe_ready, 1);

    // Push, replace-top, pop.
    send(2'b00, 32'h100, '0);
    send(2'b10, 32'h300, '0);
    send(2'b01, 32'h0, '0);
    step(); step();
    check("t1_outstanding", bus.outstanding, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Out-of-order resolution, in-order closes.
    send(2'b11, '0, 4'd0);
    send(2'b11, '0, 4'd1);
    send(2'b11, '0, 4'd2);
    check("t2_outstanding_3", bus.outstanding, 3);
    resolve(4'd2, 1'b0);
    resolve(4'd1, 1'b0);
    step(); step();
    check("t2_no_early_close", bus.outstanding, 3);
    repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    resolve(4'd0, 1'b0);
    repeat (4) step();
    check("t2_outstanding_0", bus.outstanding, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Younger mispredict flushes after the older branch closes.
    send(2'b11, '0, 4'd3);
    send(2'b11, '0, 4'd4);
    resolve(4'd4, 1'b1);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    resolve(4'd3, 1'b0);
    step();
    check("t3_ready_flush_pending", bus.fe_ready, 0);
    check("t3_outstanding_1", bus.outstanding, 1);
    step();
    check("t3_ready_flush", bus.fe_ready, 0);
    check("t3_outstanding_flush", bus.outstanding, 0);
    check("t3_flush_done_lo", bus.flush_done, 0);
    step();
    check("t3_flush_done_hi", bus.flush_done, 1);
    check("t3_ready_drain", bus.fe_ready, 0);
    step();
    check("t3_flush_done_pulse", bus.flush_done, 0);
    check("t3_ready_run", bus.fe_ready, 1);
    check("t3_queue_empty", exp_q.size(), 0);

    // Fill all tags, hold a branch-open while full, then wrap.
    step();
    rst_n = 1'b0;
    #2;
    check("async_reset_outstanding", bus.outstanding, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send(2'b11, '0, 4'(i));
    check("t4_full", bus.full, 1);
    check("t4_outstanding_16", bus.outstanding, 16);
    bus.fe_valid = 1'b1;
    bus.fe_op    = 2'b11;
    #1;
    check("t4_ready_full_branch", bus.fe_ready, 0);
    step();
    send(2'b00, 32'h200, '0);
    bus.fe_valid = 1'b1;
    bus.fe_op    = 2'b11;
    bus.rs_valid = 1'b1;
    bus.rs_tag   = 4'd0;
    bus.rs_mispredict = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    step();
    bus.rs_valid = 1'b0;
    check("t4_ready_close_cycle", bus.fe_ready, 0);
    step();
    check("t4_full_dropped", bus.full, 0);
    check("t4_outstanding_15", bus.outstanding, 15);
    send(2'b11, '0, 4'd0);
    check("t4_full_again", bus.full, 1);
    check("t4_rs_err", bus.rs_err, ErrChk);

    // Close deferred by continuous pushes until the defer limit.
    resolve(4'd1, 1'b0);
    for (int k = 0; k < 8; k++) send(2'b00, 32'h1000 + 32'(k), '0);
    bus.fe_valid = 1'b1;
    bus.fe_op    = 2'b00;
    bus.fe_data  = 32'h2000;
    #1;
    check("t5_ready_forced_low", bus.fe_ready, 0);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    step();
    bus.fe_valid = 1'b0;
    #1;
    check("t5_ready_after_close", bus.fe_ready, 1);
    check("t5_outstanding_15", bus.outstanding, 15);
    step(); step();
    check("t5_queue_empty", exp_q.size(), 0);

    // Resolution of a tag that was never opened.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_rs_err_reset", bus.rs_err, 0);
    send(2'b11, '0, 4'd0);
    resolve(4'd5, 1'b0);
    step();
    check("t6_rs_err", bus.rs_err, ErrChk);
    check("t6_outstanding", bus.outstanding, 1);
    repeat (3) step();
    check("t6_rs_err_sticky", bus.rs_err, ErrChk);
    check("t6_no_close", exp_q.size(), 0);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    resolve(4'd0, 1'b0);
    repeat (3) step();
    check("t6_outstanding_0", bus.outstanding, 0);
    check("t6_rs_err_final", bus.rs_err, ErrChk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
